// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, runtime-selectable baud rate, parity, stop bits and word length.
// Line configuration is captured at each start edge and held for the whole frame.
module uart_rx #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [1:0] baud_rate,
    input  logic [1:0] parity_type,
    input  logic       stop_bits,
    input  logic       data_length,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       parity_error,
    output logic       framing_error,
    output logic       rx_active,
    output logic       rx_done
);

    localparam int DIV_2400  = CLK_FREQ / (16 * 2400);
    localparam int DIV_4800  = CLK_FREQ / (16 * 4800);
    localparam int DIV_9600  = CLK_FREQ / (16 * 9600);
    localparam int DIV_19200 = CLK_FREQ / (16 * 19200);
    localparam int DIV_W     = $clog2(DIV_2400 + 1);

    localparam logic [DIV_W-1:0] TOP_2400  = DIV_W'(DIV_2400 - 1);
    localparam logic [DIV_W-1:0] TOP_4800  = DIV_W'(DIV_4800 - 1);
    localparam logic [DIV_W-1:0] TOP_9600  = DIV_W'(DIV_9600 - 1);
    localparam logic [DIV_W-1:0] TOP_19200 = DIV_W'(DIV_19200 - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic             sync1_r, sync2_r, prev_r;
    logic [2:0]       state_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic [DIV_W-1:0] div_top_s;
    logic [3:0]       tick_cnt_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic             par_acc_r, par_err_r, frm_err_r, second_stop_r;
    logic [1:0]       cfg_baud_r, cfg_parity_r;
    logic             cfg_stop_r, cfg_len_r;
    logic [7:0]       data_out_r;
    logic             parity_error_r, framing_error_r, rx_active_r, rx_done_r;
    logic             tick_s, edge_s, centre_s, parity_on_s;
    logic [2:0]       last_bit_s;

    // Odd parity requires XOR over data and parity bit to be 1, even requires 0.
    function automatic logic parity_fail(input logic [1:0] ptype, input logic acc, input logic pbit);
        case (ptype)
            2'b01:   parity_fail = ~(acc ^ pbit);
            2'b10:   parity_fail = acc ^ pbit;
            default: parity_fail = 1'b0;
        endcase
    endfunction

    // Bits enter at the MSB, so a 7-bit word ends up one place high in the shifter.
    function automatic logic [7:0] data_word(input logic [7:0] shift, input logic len8);
        data_word = len8 ? shift : {1'b0, shift[7:1]};
    endfunction

    assign tick_s      = (div_cnt_r == div_top_s);
    assign edge_s      = prev_r & ~sync2_r;
    assign centre_s    = tick_s && (tick_cnt_r == 4'd15);
    assign parity_on_s = (cfg_parity_r == 2'b01) || (cfg_parity_r == 2'b10);
    assign last_bit_s  = cfg_len_r ? 3'd7 : 3'd6;

    assign data_out      = data_out_r;
    assign parity_error  = parity_error_r;
    assign framing_error = framing_error_r;
    assign rx_active     = rx_active_r;
    assign rx_done       = rx_done_r;

    // Select the oversample divider terminal count from the latched baud rate.
    always_comb begin
        div_top_s = TOP_9600;
        case (cfg_baud_r)
            2'b00:   div_top_s = TOP_2400;
            2'b01:   div_top_s = TOP_4800;
            2'b10:   div_top_s = TOP_9600;
            2'b11:   div_top_s = TOP_19200;
            default: div_top_s = TOP_9600;
        endcase
    end

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clock) begin
        if (!rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= data_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Oversample divider; held at zero between frames so tick phase follows the start edge.
    always_ff @(posedge clock) begin
        if (!rst) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else if ((state_r == IDLE) || (state_r == DONE) || tick_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Frame FSM, shifter, error accumulation and registered outputs.
    always_ff @(posedge clock) begin
        if (!rst) begin
            state_r         <= IDLE;
            tick_cnt_r      <= 4'd0;
            bit_cnt_r       <= 3'd0;
            shift_r         <= 8'd0;
            par_acc_r       <= 1'b0;
            par_err_r       <= 1'b0;
            frm_err_r       <= 1'b0;
            second_stop_r   <= 1'b0;
            cfg_baud_r      <= 2'b00;
            cfg_parity_r    <= 2'b00;
            cfg_stop_r      <= 1'b0;
            cfg_len_r       <= 1'b0;
            data_out_r      <= 8'd0;
            parity_error_r  <= 1'b0;
            framing_error_r <= 1'b0;
            rx_active_r     <= 1'b0;
            rx_done_r       <= 1'b0;
        end else begin
            rx_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    tick_cnt_r <= 4'd0;
                    if (edge_s) begin
                        cfg_baud_r    <= baud_rate;
                        cfg_parity_r  <= parity_type;
                        cfg_stop_r    <= stop_bits;
                        cfg_len_r     <= data_length;
                        bit_cnt_r     <= 3'd0;
                        par_acc_r     <= 1'b0;
                        par_err_r     <= 1'b0;
                        frm_err_r     <= 1'b0;
                        second_stop_r <= 1'b0;
                        rx_active_r   <= 1'b1;
                        state_r       <= START;
                    end
                end
                START: begin
                    if (tick_s) begin
                        if (tick_cnt_r == 4'd7) begin
                            tick_cnt_r <= 4'd0;
                            if (sync2_r) begin
                                rx_active_r <= 1'b0;
                                state_r     <= IDLE;
                            end else begin
                                state_r <= DATA;
                            end
                        end else begin
                            tick_cnt_r <= tick_cnt_r + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        tick_cnt_r <= tick_cnt_r + 4'd1;
                        if (tick_cnt_r == 4'd15) begin
                            shift_r   <= {sync2_r, shift_r[7:1]};
                            par_acc_r <= par_acc_r ^ sync2_r;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == last_bit_s) begin
                                state_r <= parity_on_s ? PARITY : STOP;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (tick_s) begin
                        tick_cnt_r <= tick_cnt_r + 4'd1;
                    end
                    if (centre_s) begin
                        par_err_r <= parity_fail(cfg_parity_r, par_acc_r, sync2_r);
                        state_r   <= STOP;
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        tick_cnt_r <= tick_cnt_r + 4'd1;
                    end
                    // Leave at the centre of the last stop bit so a following start edge is not missed.
                    if (centre_s) begin
                        if (cfg_stop_r && !second_stop_r) begin
                            second_stop_r <= 1'b1;
                            frm_err_r     <= ~sync2_r;
                        end else begin
                            data_out_r      <= data_word(shift_r, cfg_len_r);
                            parity_error_r  <= par_err_r;
                            framing_error_r <= frm_err_r | ~sync2_r;
                            rx_done_r       <= 1'b1;
                            rx_active_r     <= 1'b0;
                            state_r         <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    rx_active_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed serial frames, expected words queued at send time,
// a monitor pops and compares on every rx_done pulse.
module tb_uart_rx;

    localparam int CLK_FREQ = 1500000;
    // CLK_FREQ/(16*baud), truncated: 39.06, 19.53, 9.76, 4.88
    localparam int DIV_2400  = 39;
    localparam int DIV_4800  = 19;
    localparam int DIV_9600  = 9;
    localparam int DIV_19200 = 4;

    logic       clock = 1'b0;
    logic       rst;
    logic [1:0] baud_rate;
    logic [1:0] parity_type;
    logic       stop_bits;
    logic       data_length;
    logic       data_in;
    logic [7:0] data_out;
    logic       parity_error;
    logic       framing_error;
    logic       rx_active;
    logic       rx_done;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;
    int   done_cnt   = 0;
    int   active_cnt = 0;
    logic prev_done  = 1'b0;

    uart_rx #(.CLK_FREQ(CLK_FREQ)) dut (
        .clock        (clock),
        .rst          (rst),
        .baud_rate    (baud_rate),
        .parity_type  (parity_type),
        .stop_bits    (stop_bits),
        .data_length  (data_length),
        .data_in      (data_in),
        .data_out     (data_out),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .rx_active    (rx_active),
        .rx_done      (rx_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: compares every completed frame against the head of the scoreboard.
    always @(negedge clock) begin
        if (rx_active) active_cnt++;
        if (rx_done) begin
            done_cnt++;
            check("rx_done_width", {31'd0, prev_done}, 32'd0);
            check("rx_active_in_done", {31'd0, rx_active}, 32'd0);
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_rx_done: got data_out %0h, expected no frame", data_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("data_out", {24'd0, data_out}, {24'd0, mon_e.data});
                check("parity_error", {31'd0, parity_error}, {31'd0, mon_e.pe});
                check("framing_error", {31'd0, framing_error}, {31'd0, mon_e.fe});
            end
        end
        prev_done = rx_done;
    end

    task automatic drive_bit(input logic b, input int bclk);
        data_in = b;
        repeat (bclk) @(negedge clock);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.pe   = pe;
        e.fe   = fe;
        exp_q.push_back(e);
    endtask

    // pmode: 0 none, 1 odd, 2 even; scramble flips the config inputs once the start bit is out.
    task automatic send_frame(input logic [7:0] d, input int nbits, input int pmode, input bit bad_par,
                              input int nstop, input bit stop_low, input int bclk, input bit scramble);
        logic [7:0] mask;
        logic       p;
        logic [1:0] sv_baud, sv_par;
        logic       sv_stop, sv_len;
        sv_baud = baud_rate;
        sv_par  = parity_type;
        sv_stop = stop_bits;
        sv_len  = data_length;
        drive_bit(1'b0, bclk);
        if (scramble) begin
            baud_rate   = ~sv_baud;
            parity_type = ~sv_par;
            stop_bits   = ~sv_stop;
            data_length = ~sv_len;
        end
        for (int i = 0; i < nbits; i++) drive_bit(d[i], bclk);
        if (pmode != 0) begin
            mask = (nbits == 8) ? 8'hFF : 8'h7F;
            p = ^(d & mask);
            if (pmode == 1) p = ~p;
            if (bad_par) p = ~p;
            drive_bit(p, bclk);
        end
        for (int i = 0; i < nstop; i++) drive_bit((stop_low && i == 0) ? 1'b0 : 1'b1, bclk);
        data_in     = 1'b1;
        baud_rate   = sv_baud;
        parity_type = sv_par;
        stop_bits   = sv_stop;
        data_length = sv_len;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clock);
            n++;
        end
        check(name, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic set_cfg(input logic [1:0] b, input logic [1:0] p, input logic s, input logic l);
        baud_rate   = b;
        parity_type = p;
        stop_bits   = s;
        data_length = l;
    endtask

    initial begin
        int done_before;
        rst     = 1'b0;
        data_in = 1'b1;
        set_cfg(2'b10, 2'b00, 1'b0, 1'b1);
        repeat (5) @(negedge clock);
        check("reset_data_out", {24'd0, data_out}, 32'd0);
        check("reset_parity_error", {31'd0, parity_error}, 32'd0);
        check("reset_framing_error", {31'd0, framing_error}, 32'd0);
        check("reset_rx_active", {31'd0, rx_active}, 32'd0);
        check("reset_rx_done", {31'd0, rx_done}, 32'd0);
        rst = 1'b1;
        repeat (20) @(negedge clock);

        // 9600 8N1 0xA5, config inputs scrambled mid-frame
        active_cnt = 0;
        expect_frame(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 0, 1'b0, 1, 1'b0, 16 * DIV_9600, 1'b1);
        wait_drain("drain_a5", 20 * 16 * DIV_9600);
        repeat (2 * 16 * DIV_9600) @(negedge clock);
        // half start bit + 8 data bits + 1 stop bit = 152 ticks
        check("rx_active_cycles", active_cnt, 152 * DIV_9600);

        // 19200 7E2 0x53: good parity then bad parity
        set_cfg(2'b11, 2'b10, 1'b1, 1'b0);
        expect_frame(8'h53, 1'b0, 1'b0);
        send_frame(8'h53, 7, 2, 1'b0, 2, 1'b0, 16 * DIV_19200, 1'b0);
        repeat (2 * 16 * DIV_19200) @(negedge clock);
        expect_frame(8'h53, 1'b1, 1'b0);
        send_frame(8'h53, 7, 2, 1'b1, 2, 1'b0, 16 * DIV_19200, 1'b0);
        wait_drain("drain_53", 20 * 16 * DIV_19200);
        repeat (2 * 16 * DIV_19200) @(negedge clock);

        // reset pulsed during data bit 4 of 9600 8N1 0xC3
        set_cfg(2'b10, 2'b00, 1'b0, 1'b1);
        drive_bit(1'b0, 16 * DIV_9600);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'hC3 >> i), 16 * DIV_9600);
        drive_bit(1'b0, 8 * DIV_9600);
        check("mid_frame_rx_active", {31'd0, rx_active}, 32'd1);
        rst = 1'b0;
        @(negedge clock);
        check("midrst_data_out", {24'd0, data_out}, 32'd0);
        check("midrst_parity_error", {31'd0, parity_error}, 32'd0);
        check("midrst_framing_error", {31'd0, framing_error}, 32'd0);
        check("midrst_rx_active", {31'd0, rx_active}, 32'd0);
        repeat (2) @(negedge clock);
        rst     = 1'b1;
        data_in = 1'b1;
        repeat (5 * 16 * DIV_9600) @(negedge clock);
        expect_frame(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 8, 0, 1'b0, 1, 1'b0, 16 * DIV_9600, 1'b0);
        wait_drain("drain_81", 20 * 16 * DIV_9600);
        repeat (2 * 16 * DIV_9600) @(negedge clock);

        // 2400 8N1: stop bit low, then a clean frame
        set_cfg(2'b00, 2'b00, 1'b0, 1'b1);
        expect_frame(8'h5A, 1'b0, 1'b1);
        send_frame(8'h5A, 8, 0, 1'b0, 1, 1'b1, 16 * DIV_2400, 1'b0);
        repeat (2 * 16 * DIV_2400) @(negedge clock);
        expect_frame(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 8, 0, 1'b0, 1, 1'b0, 16 * DIV_2400, 1'b0);
        wait_drain("drain_3c", 20 * 16 * DIV_2400);
        repeat (2 * 16 * DIV_2400) @(negedge clock);

        // 3-tick low glitch at 9600 must be rejected
        set_cfg(2'b10, 2'b00, 1'b0, 1'b1);
        done_before = done_cnt;
        drive_bit(1'b0, 3 * DIV_9600);
        drive_bit(1'b1, 2 * 16 * DIV_9600);
        check("glitch_rx_active", {31'd0, rx_active}, 32'd0);
        check("glitch_no_done", done_cnt, done_before);

        // back-to-back 4800 8O1 frames with no idle gap
        set_cfg(2'b01, 2'b01, 1'b0, 1'b1);
        expect_frame(8'h00, 1'b0, 1'b0);
        expect_frame(8'hFF, 1'b0, 1'b0);
        send_frame(8'h00, 8, 1, 1'b0, 1, 1'b0, 16 * DIV_4800, 1'b0);
        send_frame(8'hFF, 8, 1, 1'b0, 1, 1'b0, 16 * DIV_4800, 1'b0);
        wait_drain("drain_b2b", 30 * 16 * DIV_4800);
        repeat (2 * 16 * DIV_4800) @(negedge clock);

        check("total_rx_done", done_cnt, 32'd8);
        check("final_rx_active", {31'd0, rx_active}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Port: clock  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-low.
REQ-004 Port: baud_rate  input  2  rate select: 00=2400, 01=4800, 10=9600, 11=19200 baud.
REQ-005 Port: parity_type  input  2  00=none, 01=odd, 10=even, 11=none.
REQ-006 Port: stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
REQ-007 Port: data_length  input  1  0 = 7 data bits, 1 = 8 data bits.
REQ-008 Port: data_in  input  1  serial line, idle high, asynchronous to clock.
REQ-009 Port: data_out  output  8  received word, LSB = first bit received.
REQ-010 Port: parity_error  output  1  parity check failed for last frame.
REQ-011 Port: framing_error  output  1  a stop bit was sampled low in last frame.
REQ-012 Port: rx_active  output  1  high while a frame is being received.
REQ-013 Port: rx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-014 data_in SHALL pass through a 2-flop synchronizer; both flops reset to 1.
REQ-015 Oversample tick SHALL pulse one clock every DIV = CLK_FREQ/(16*baud) clocks (integer truncation); the divider counter clears in IDLE so that tick phase aligns to start-edge detection.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
REQ-017 IDLE: on synchronized 1->0 transition, latch baud_rate, parity_type, stop_bits and data_length, go to START, clear tick counter; config changes mid-frame SHALL be ignored.
REQ-018 START: at 8th tick re-sample the line; low -> DATA; high -> IDLE (glitch rejected, no rx_done).
REQ-019 DATA: sample every 16 ticks (bit centre), shift LSB-first, 7 or 8 bits per latched data_length.
REQ-020 In 7-bit mode data_out[7] SHALL be 0.
REQ-021 PARITY entered only when latched parity_type is 01 or 10; one bit sampled at centre; otherwise DATA -> STOP directly.
REQ-022 Parity check: odd -> XOR(data bits, parity bit) must be 1; even -> must be 0; mismatch sets parity_error; none -> parity_error = 0.
REQ-023 STOP: sample first stop bit at centre; if latched stop_bits = 1, sample second stop bit 16 ticks later; any low sample sets framing_error.
REQ-024 DONE: lasts exactly one clock; data_out, parity_error, framing_error update in this cycle; rx_done = 1; next state IDLE.
REQ-025 Transition to DONE SHALL occur at the centre of the last stop bit, so a start edge immediately following it is detected.
REQ-026 data_out, parity_error and framing_error SHALL hold until the next DONE; they are updated even when errors are flagged.
REQ-027 rx_active = 1 in START, DATA, PARITY, STOP; 0 in IDLE and DONE.
REQ-028 Frames with framing errors SHALL not stall the FSM; a low line after DONE is treated as a new start edge only after a 1->0 transition is seen.

Reset
REQ-029 While rst = 0 at a clock edge: state IDLE, counters 0, synchronizer 1, data_out = 0, parity_error = 0, framing_error = 0, rx_active = 0, rx_done = 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no rx_done pulse; reception resumes from IDLE on the next start edge after release.

Verification
REQ-031 9600 baud, 8N1, send 0xA5 -> one rx_done pulse, data_out = 0xA5, both error flags 0, rx_active high ~10 bit times (DIV = 325 clocks per tick).
REQ-032 19200 baud, 7 data, even parity, 2 stop, send 0x53 with correct parity bit 0 -> data_out = 0x53, parity_error = 0; repeat with parity bit 1 -> parity_error = 1, data_out = 0x53.
REQ-033 2400 baud, 8N1, stop bit driven low -> framing_error = 1, rx_done pulses, next frame 0x3C received cleanly with framing_error = 0.
REQ-034 Low glitch of 3 ticks on idle line -> no rx_done, rx_active returns to 0, state IDLE.
REQ-035 Reset pulsed during DATA bit 4 -> no rx_done, all outputs 0; following frame 0x81 received correctly.
REQ-036 Back-to-back 8O1 frames 0x00, 0xFF with no idle gap -> two rx_done pulses, data_out 0x00 then 0xFF, no errors.
